global_io_ctrl: RTL and testbench
=================================

Name: global_io_ctrl

Overview:
- Sequencer on the control side of global_io: accepts an accumulation request, drives global_io's st, acm_en and wwidth, then captures global_io's nout.
- Returns the captured result through a valid/ready response port.
- Sits between the macro-level scheduler and global_io. macout_a/macout_b are not routed through this block; only control and result pass through it.

Parameters:
- NOUT_W, 51, width of nout_in and rsp_data (matches global_io nout).
- CNT_W, 8, width of the accumulation length field; maximum length is 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_len  in  CNT_W  number of accumulation cycles.
- req_wwidth  in  1  0 = 12-bit weight mode, 1 = 24-bit weight mode (b<<12 + a).
- st  out  1  to global_io: clears its accumulator.
- acm_en  out  1  to global_io: accumulate enable.
- wwidth  out  1  to global_io: weight width select.
- nout_in  in  NOUT_W  from global_io nout (registered in global_io).
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted by consumer.
- rsp_data  out  NOUT_W  captured accumulation result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (async, rst=1): state=IDLE; st=0; acm_en=0; wwidth=0; rsp_valid=0; rsp_data=0; internal counter=0; busy=0. req_ready=1 once rst deasserts.
- States: IDLE, CLEAR, ACCUM, SETTLE, HOLD. All outputs are registered except req_ready and busy, which decode the state.
- IDLE:
  - req_ready=1; st=0; acm_en=0.
  - On req_valid&&req_ready: latch len into cnt and req_wwidth into the wwidth output, then go to CLEAR.
- CLEAR:
  - Exactly one cycle with st=1, acm_en=0.
  - Next state is ACCUM if len!=0, else SETTLE.
- ACCUM:
  - st=0, acm_en=1 for exactly len consecutive cycles; cnt decrements each cycle.
  - Leave when cnt==1 (last cycle), going to SETTLE.
- SETTLE:
  - One cycle with acm_en=0, st=0.
  - global_io updated nout on the last ACCUM edge. At the end of SETTLE: rsp_data<=nout_in, rsp_valid<=1, go to HOLD.
- HOLD:
  - rsp_valid=1 and rsp_data stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, go to IDLE.
- Request/response rules:
  - req_ready is low in CLEAR, ACCUM, SETTLE and HOLD; there is no request overlap.
  - rsp_ready is ignored outside HOLD.
  - rsp_ready held high gives a one-cycle HOLD.
- Latency, request acceptance to rsp_valid: len+3 cycles (CLEAR + len ACCUM + SETTLE, plus the HOLD entry edge).
- wwidth stays constant from acceptance until the next acceptance. global_io therefore sees a stable width across CLEAR..SETTLE.
- len=0: sequence is CLEAR, SETTLE, HOLD; result is the value global_io holds after st (0).
- len=2^CNT_W-1: counter must not wrap; exactly that many acm_en cycles are issued.
- rst mid-transaction: immediate return to IDLE with all outputs at reset values. Any partial result is discarded and no rsp is issued.
- Simultaneous rsp handshake and a new req_valid in HOLD: the request is not accepted that cycle. It is accepted in the following IDLE cycle.

Optional Feature:
- Macro ACCUM_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - In ACCUM, stall=1 forces acm_en=0 and freezes cnt; the cycle does not count toward len.
  - stall is ignored in all other states.
  - Result equals the sum over the non-stalled cycles only.
- Undefined: no stall port; ACCUM is exactly len contiguous cycles.

Decomposition:
- Shared package gio_pkg:
  - state enum (IDLE, CLEAR, ACCUM, SETTLE, HOLD);
  - NOUT_W default constant 51;
  - WWIDTH_12 = 0, WWIDTH_24 = 1;
  - shift constant 12 for 24-bit mode (used by benches/models).
- No sub-module required; the counter stays inline in the FSM.

Test Plan (bench pairs global_io_ctrl with global_io and drives macout_a/macout_b per ACCUM cycle):
- Reset: rst=1 mid-ACCUM -> next cycle st=0, acm_en=0, rsp_valid=0, busy=0, req_ready=1; no rsp afterwards.
- 12-bit mode: req_len=3, wwidth=0, macout_a=10,20,30, macout_b ignored -> rsp_data=60; rsp_valid 6 cycles after acceptance; exactly one st pulse and 3 acm_en cycles.
- 24-bit mode: req_len=2, wwidth=1, (a,b)=(10,1),(20,2) -> rsp_data=4106+8212=12318; wwidth stable throughout.
- Back-pressure: rsp_ready=0 for 5 cycles in HOLD -> rsp_valid and rsp_data=60 held; req_valid ignored; rsp_ready=1 returns to IDLE next cycle.
- Boundaries: req_len=0 -> rsp_data=0 after CLEAR/SETTLE. req_len=255 with a=1 -> rsp_data=255 and exactly 255 acm_en cycles.
- ACCUM_STALL_EN: req_len=3, a=5 every cycle, stall high 2 cycles mid-ACCUM -> 5 ACCUM cycles total, acm_en high 3 of them, rsp_data=15.

Source files
------------

// File: rtl/gio_pkg.sv
// Shared definitions for the global_io control path: sequencer states and
// weight-width encodings used by global_io_ctrl and its models.
package gio_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCUM  = 3'd2,
    SETTLE = 3'd3,
    HOLD   = 3'd4
  } gio_state_t;

  localparam int   NOUT_W_DEF   = 51;
  localparam logic WWIDTH_12    = 1'b0;
  localparam logic WWIDTH_24    = 1'b1;
  // In 24-bit mode global_io accumulates (b << WWIDTH_SHIFT) + a.
  localparam int   WWIDTH_SHIFT = 12;

endpackage

// File: rtl/global_io_ctrl.sv
// Sequencer driving global_io's st/acm_en/wwidth and returning its nout via a
// valid/ready response port. Optional macro ACCUM_STALL_EN adds a stall input.
module global_io_ctrl
  import gio_pkg::*;
#(
  parameter int NOUT_W = NOUT_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CNT_W-1:0]  req_len,
  input  logic              req_wwidth,
  output logic              st,
  output logic              acm_en,
  output logic              wwidth,
  input  logic [NOUT_W-1:0] nout_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [NOUT_W-1:0] rsp_data,
`ifdef ACCUM_STALL_EN
  input  logic              stall,
`endif
  output logic              busy
);

  gio_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             acm_q;
  logic             stall_w;

`ifdef ACCUM_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // acm_q is only ever set in ACCUM, so stall is effectively ignored elsewhere.
  assign acm_en    = acm_q & ~stall_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      st        <= 1'b0;
      acm_q     <= 1'b0;
      wwidth    <= WWIDTH_12;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            cnt    <= req_len;
            wwidth <= req_wwidth;
            st     <= 1'b1;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          st <= 1'b0;
          if (cnt != '0) begin
            acm_q <= 1'b1;
            state <= ACCUM;
          end else begin
            state <= SETTLE;
          end
        end
        ACCUM: begin
          // A stalled cycle neither counts toward len nor advances the FSM.
          if (!stall_w) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              acm_q <= 1'b0;
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          rsp_data  <= nout_in;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_global_io_ctrl.sv
// Bench for global_io_ctrl paired with a behavioural global_io accumulator;
// covers both 12/24-bit modes, back-pressure, boundaries, reset and stall.
module tb_global_io_ctrl;
  import gio_pkg::*;

  localparam int NW = 51;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [CW-1:0] req_len = '0;
  logic          req_wwidth = 1'b0;
  logic          st, acm_en, wwidth;
  logic [NW-1:0] nout_in;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [NW-1:0] rsp_data;
  logic          busy;
`ifdef ACCUM_STALL_EN
  logic          stall = 1'b0;
  int            stall_at = 0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  global_io_ctrl #(.NOUT_W(NW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .req_wwidth(req_wwidth),
    .st(st), .acm_en(acm_en), .wwidth(wwidth), .nout_in(nout_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef ACCUM_STALL_EN
    .stall(stall),
`endif
    .busy(busy)
  );

  // Behavioural global_io: clear on st, add one macout pair per acm_en edge.
  logic [11:0]   a_arr [256];
  logic [11:0]   b_arr [256];
  logic [NW-1:0] acc;
  int            k;
  int            st_cnt = 0;
  int            acm_cnt = 0;

  assign nout_in = acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      k   <= 0;
    end else if (st) begin
      acc <= '0;
      k   <= 0;
    end else if (acm_en) begin
      if (wwidth == WWIDTH_24)
        acc <= acc + (NW'(b_arr[k]) << WWIDTH_SHIFT) + NW'(a_arr[k]);
      else
        acc <= acc + NW'(a_arr[k]);
      k <= k + 1;
    end
  end

  always @(posedge clk) begin
    if (st)     st_cnt  <= st_cnt + 1;
    if (acm_en) acm_cnt <= acm_cnt + 1;
  end

  function automatic logic [63:0] exp_sum(input int len, input logic ww);
    longint s = 0;
    for (int i = 0; i < len; i++)
      s += ww ? (longint'(b_arr[i]) * 4096 + longint'(a_arr[i])) : longint'(a_arr[i]);
    return 64'(s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) begin
      a_arr[i] = 12'($urandom);
      b_arr[i] = 12'($urandom);
    end
  endtask

  // One full request/response; bp = cycles of rsp_ready low in HOLD (0 = held high).
  task automatic run_txn(input string tag, input int len, input logic ww, input int bp);
    int            cyc;
    int            st0, acm0, ww_bad, extra;
    logic [63:0]   expv;
    logic [NW-1:0] held;
    expv  = exp_sum(len, ww);
    extra = 0;
    cyc   = 0;
    while (!req_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
    st0 = st_cnt; acm0 = acm_cnt;
    rsp_ready  = (bp == 0);
    req_valid  = 1'b1;
    req_len    = CW'(len);
    req_wwidth = ww;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_len    = CW'($urandom);
    req_wwidth = 1'($urandom);
    chk({tag, " st in CLEAR"}, 64'(st), 64'd1);
    chk({tag, " req_ready busy"}, 64'({req_ready, busy}), 64'b01);
    cyc = 1;
    ww_bad = 0;
    while (!rsp_valid && cyc < 600) begin
`ifdef ACCUM_STALL_EN
      stall = (stall_at > 0) && (cyc == stall_at || cyc == stall_at + 1);
      if (stall) extra++;
`endif
      @(posedge clk); #1; cyc++;
      if (wwidth !== ww) ww_bad++;
    end
`ifdef ACCUM_STALL_EN
    stall = 1'b0;
`endif
    chk({tag, " latency"}, 64'(cyc), 64'(len + 3 + extra));
    chk({tag, " rsp_data"}, 64'(rsp_data), expv);
    chk({tag, " acm_en cycles"}, 64'(acm_cnt - acm0), 64'(len));
    chk({tag, " st pulses"}, 64'(st_cnt - st0), 64'd1);
    chk({tag, " wwidth stable"}, 64'(ww_bad), 64'd0);
    held = rsp_data;
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, " hold valid/ready"}, 64'({rsp_valid, req_ready}), 64'b10);
      chk({tag, " hold data"}, 64'(rsp_data), 64'(held));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " release"}, 64'({rsp_valid, busy, req_ready}), 64'b001);
    req_valid = 1'b0;
  endtask

  initial begin
    fill_rand();
    #2 rst = 1'b1;
    #2;
    chk("reset outputs", 64'({st, acm_en, wwidth, rsp_valid, busy, req_ready}), 64'b000001);
    chk("reset rsp_data", 64'(rsp_data), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // 12-bit directed with back-pressure; b is noise that must be ignored.
    a_arr[0] = 12'd10; a_arr[1] = 12'd20; a_arr[2] = 12'd30;
    run_txn("m12", 3, WWIDTH_12, 5);
    chk("m12 const", 64'(rsp_data), 64'd60);

    // 24-bit directed.
    a_arr[0] = 12'd10; b_arr[0] = 12'd1;
    a_arr[1] = 12'd20; b_arr[1] = 12'd2;
    run_txn("m24", 2, WWIDTH_24, 0);
    chk("m24 const", 64'(rsp_data), 64'd12318);

    run_txn("len0", 0, WWIDTH_24, 1);
    chk("len0 const", 64'(rsp_data), 64'd0);

    for (int i = 0; i < 256; i++) a_arr[i] = 12'd1;
    run_txn("len255", 255, WWIDTH_12, 0);
    chk("len255 const", 64'(rsp_data), 64'd255);

    for (int t = 0; t < 6; t++) begin
      fill_rand();
      run_txn($sformatf("rand%0d", t), int'($urandom_range(1, 20)), 1'($urandom),
              int'($urandom_range(0, 3)));
    end

`ifdef ACCUM_STALL_EN
    for (int i = 0; i < 256; i++) a_arr[i] = 12'd5;
    stall_at = 3;
    run_txn("stall", 3, WWIDTH_12, 0);
    chk("stall const", 64'(rsp_data), 64'd15);
    stall_at = 0;
`endif

    // Reset in the middle of ACCUM: everything returns to idle, no response.
    begin
      int acm0, seen;
      fill_rand();
      req_valid = 1'b1; req_len = CW'(10); req_wwidth = WWIDTH_12;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre-rst acm_en", 64'(acm_en), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid-rst outputs", 64'({st, acm_en, wwidth, rsp_valid, busy, req_ready}), 64'b000001);
      chk("mid-rst rsp_data", 64'(rsp_data), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      acm0 = acm_cnt;
      seen = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (rsp_valid || busy) seen++;
      end
      chk("post-rst no rsp", 64'(seen), 64'd0);
      chk("post-rst no acm", 64'(acm_cnt - acm0), 64'd0);
    end

    fill_rand();
    run_txn("after-rst", 4, WWIDTH_24, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
